// File: rtl/or1200_fwd_pkg.sv
// Shared encodings and types for the operand forwarding / load-use hazard controller.
package or1200_fwd_pkg;

    localparam int FWD_AW = 5;

    localparam logic [1:0] SEL_RF      = 2'd0;
    localparam logic [1:0] SEL_IMM     = 2'd1;
    localparam logic [1:0] SEL_EX_FORW = 2'd2;
    localparam logic [1:0] SEL_WB_FORW = 2'd3;

    typedef struct packed {
        logic              vld;
        logic [FWD_AW-1:0] addr;
        logic              load;
    } wb_slot_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } fwd_state_t;

endpackage

// File: rtl/or1200_fwd_match.sv
// Compares one shadow-pipeline slot against an ID source address; r0 never matches.
module or1200_fwd_match
    import or1200_fwd_pkg::*;
#(
    parameter int AW = FWD_AW
) (
    input  logic          slot_vld,
    input  logic [AW-1:0] slot_addr,
    input  logic [AW-1:0] id_addr,
    output logic          hit
);

    assign hit = slot_vld && (slot_addr == id_addr) && (id_addr != '0);

endmodule

// File: rtl/or1200_fwd_ctrl.sv
// Operand forwarding select and load-use stall generation, driven by a two-slot
// shadow of the destination registers currently in EX and WB.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no stall owed; hz_stall follows the combinational load-use hazard
//   STALL | extra load bubbles still owed; cnt = STALL cycles left incl. this
module or1200_fwd_ctrl
    import or1200_fwd_pkg::*;
#(
    parameter int AW       = FWD_AW,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_freeze,
    input  logic          ex_freeze,
    input  logic          flushpipe,
    input  logic [AW-1:0] id_rfaddra,
    input  logic [AW-1:0] id_rfaddrb,
    input  logic          id_rfa_used,
    input  logic          id_rfb_used,
    input  logic          id_sel_imm,
    input  logic [AW-1:0] id_rfaddrw,
    input  logic          id_rfwb,
    input  logic          id_is_load,
    output logic [1:0]    sel_a,
    output logic [1:0]    sel_b,
    output logic          hz_stall
);

    wb_slot_t        ex_slot;
    wb_slot_t        wb_slot;
    fwd_state_t      state_q;
    fwd_state_t      state_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            ex_a;
    logic            wb_a;
    logic            ex_b;
    logic            wb_b;
    logic            haz;

    or1200_fwd_match #(.AW(AW)) u_match_ex_a (
        .slot_vld  (ex_slot.vld),
        .slot_addr (ex_slot.addr),
        .id_addr   (id_rfaddra),
        .hit       (ex_a)
    );

    or1200_fwd_match #(.AW(AW)) u_match_wb_a (
        .slot_vld  (wb_slot.vld),
        .slot_addr (wb_slot.addr),
        .id_addr   (id_rfaddra),
        .hit       (wb_a)
    );

    or1200_fwd_match #(.AW(AW)) u_match_ex_b (
        .slot_vld  (ex_slot.vld),
        .slot_addr (ex_slot.addr),
        .id_addr   (id_rfaddrb),
        .hit       (ex_b)
    );

    or1200_fwd_match #(.AW(AW)) u_match_wb_b (
        .slot_vld  (wb_slot.vld),
        .slot_addr (wb_slot.addr),
        .id_addr   (id_rfaddrb),
        .hit       (wb_b)
    );

    always_comb begin
        sel_a = SEL_RF;
        if (id_rfa_used) begin
            if (ex_a)      sel_a = SEL_EX_FORW;
            else if (wb_a) sel_a = SEL_WB_FORW;
        end

        sel_b = SEL_RF;
        if (id_sel_imm) begin
            sel_b = SEL_IMM;
        end else if (id_rfb_used) begin
            if (ex_b)      sel_b = SEL_EX_FORW;
            else if (wb_b) sel_b = SEL_WB_FORW;
        end
    end

    assign haz = ex_slot.load && ((ex_a && id_rfa_used) ||
                                  (ex_b && id_rfb_used && !id_sel_imm));

    // The IDLE hazard cycle is itself the first bubble, so STALL covers LOAD_LAT-1 more.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hz_stall = 1'b0;
        case (state_q)
            IDLE: begin
                hz_stall = haz;
                if (haz && !ex_freeze && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = CNTW'(LOAD_LAT - 1);
                end
            end
            STALL: begin
                hz_stall = 1'b1;
                if (!ex_freeze) begin
                    if (cnt_q == CNTW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flushpipe) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ex_slot <= '0;
            wb_slot <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flushpipe) begin
                ex_slot <= '0;
                wb_slot <= '0;
            end else if (!ex_freeze) begin
                wb_slot <= ex_slot;
                if (id_freeze || hz_stall) ex_slot <= '0;
                else                       ex_slot <= {id_rfwb, id_rfaddrw, id_is_load};
            end
        end
    end

endmodule

// File: tb/tb_or1200_fwd_ctrl.sv
// Directed bench for or1200_fwd_ctrl: a LOAD_LAT=1 and a LOAD_LAT=2 instance share stimulus.
module tb_or1200_fwd_ctrl;
    import or1200_fwd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_freeze;
    logic       ex_freeze;
    logic       flushpipe;
    logic [4:0] id_rfaddra;
    logic [4:0] id_rfaddrb;
    logic       id_rfa_used;
    logic       id_rfb_used;
    logic       id_sel_imm;
    logic [4:0] id_rfaddrw;
    logic       id_rfwb;
    logic       id_is_load;
    logic [1:0] sel_a1, sel_b1, sel_a2, sel_b2;
    logic       hz1, hz2;

    int n_pass  = 0;
    int n_total = 0;
    int hz_cnt;

    always #5 clk = ~clk;

    or1200_fwd_ctrl #(.AW(5), .LOAD_LAT(1), .CNTW(2)) u_dut1 (
        .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
        .flushpipe(flushpipe), .id_rfaddra(id_rfaddra), .id_rfaddrb(id_rfaddrb),
        .id_rfa_used(id_rfa_used), .id_rfb_used(id_rfb_used), .id_sel_imm(id_sel_imm),
        .id_rfaddrw(id_rfaddrw), .id_rfwb(id_rfwb), .id_is_load(id_is_load),
        .sel_a(sel_a1), .sel_b(sel_b1), .hz_stall(hz1)
    );

    or1200_fwd_ctrl #(.AW(5), .LOAD_LAT(2), .CNTW(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
        .flushpipe(flushpipe), .id_rfaddra(id_rfaddra), .id_rfaddrb(id_rfaddrb),
        .id_rfa_used(id_rfa_used), .id_rfb_used(id_rfb_used), .id_sel_imm(id_sel_imm),
        .id_rfaddrw(id_rfaddrw), .id_rfwb(id_rfwb), .id_is_load(id_is_load),
        .sel_a(sel_a2), .sel_b(sel_b2), .hz_stall(hz2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                          input logic ub, input logic imm, input logic [4:0] rw,
                          input logic wb, input logic ld);
        id_rfaddra  = ra;
        id_rfa_used = ua;
        id_rfaddrb  = rb;
        id_rfb_used = ub;
        id_sel_imm  = imm;
        id_rfaddrw  = rw;
        id_rfwb     = wb;
        id_is_load  = ld;
    endtask

    initial begin
        rst = 1'b1; id_freeze = 1'b0; ex_freeze = 1'b0; flushpipe = 1'b0;
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // reset state
        tick(); tick(); #1;
        chk("rst_sel_a", sel_a1, SEL_RF);
        chk("rst_sel_b", sel_b1, SEL_RF);
        chk("rst_hz1", hz1, 1'b0);
        chk("rst_hz2", hz2, 1'b0);
        id_sel_imm = 1'b1; #1;
        chk("rst_sel_b_imm", sel_b1, SEL_IMM);

        // ALU writes r3, consumer reads A=r3
        rst = 1'b0;
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        id_set(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        chk("alu_ex_fwd_a", sel_a1, SEL_EX_FORW);
        chk("alu_no_hz", hz1, 1'b0);
        tick(); #1;
        chk("alu_wb_fwd_a", sel_a1, SEL_WB_FORW);
        id_rfaddrb = 5'd3; id_rfb_used = 1'b1; #1;
        chk("alu_wb_fwd_b", sel_b1, SEL_WB_FORW);
        id_rfb_used = 1'b0; #1;
        chk("unused_b_rf", sel_b1, SEL_RF);
        id_rfa_used = 1'b0; #1;
        chk("unused_a_rf", sel_a1, SEL_RF);
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(); tick();

        // load r5, consumer reads B=r5 (LOAD_LAT=1)
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        id_set(5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); #1;
        chk("imm_masks_haz", hz1, 1'b0);
        chk("imm_sel_b", sel_b1, SEL_IMM);
        id_sel_imm = 1'b0; #1;
        chk("lu_hz_on", hz1, 1'b1);
        chk("lu_sel_b_ex", sel_b1, SEL_EX_FORW);
        tick(); #1;
        chk("lat1_hz_off", hz1, 1'b0);
        chk("lat1_sel_b_wb", sel_b1, SEL_WB_FORW);
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(); tick(); tick();

        // LOAD_LAT=2 with ex_freeze held for 3 cycles mid-stall
        rst = 1'b1; tick(); rst = 1'b0;
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        id_set(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        chk("lat2_hz_first", hz2, 1'b1);
        hz_cnt = hz2 ? 1 : 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            ex_freeze = (i <= 3);
            #1;
            if (hz2) hz_cnt++;
        end
        chk("lat2_hz_cycles", 8'(hz_cnt), 8'd5);
        chk("lat2_hz_end", hz2, 1'b0);

        // r0 never forwards; EX wins over WB
        ex_freeze = 1'b0;
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        id_set(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); #1;
        chk("r0_no_fwd", sel_a1, SEL_RF);
        tick(); tick();
        id_set(5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        chk("ex_wins_a", sel_a1, SEL_EX_FORW);
        chk("ex_wins_b", sel_b1, SEL_EX_FORW);
        tick(); #1;
        chk("r7_wb_only", sel_a1, SEL_WB_FORW);

        // hazard and flush in the same cycle
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        id_set(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        flushpipe = 1'b1; #1;
        chk("flush_cycle_hz", hz2, 1'b1);
        tick();
        flushpipe = 1'b0; #1;
        chk("flush_no_stall", hz2, 1'b0);
        chk("flush_clr_sel_b", sel_b2, SEL_RF);

        // flush while frozen in STALL
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        id_set(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        ex_freeze = 1'b1; #1;
        chk("stall_frozen_hz", hz2, 1'b1);
        flushpipe = 1'b1;
        tick();
        flushpipe = 1'b0; #1;
        chk("flush_mid_stall", hz2, 1'b0);
        chk("flush_mid_sel_b", sel_b2, SEL_RF);

        // reset while frozen in STALL
        ex_freeze = 1'b0;
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        id_set(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        id_set(5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        ex_freeze = 1'b1; #1;
        chk("stall_before_rst", hz2, 1'b1);
        rst = 1'b1;
        tick(); #1;
        chk("rst_mid_stall", hz2, 1'b0);
        rst = 1'b0; ex_freeze = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
